esfa_test_sequencer: RTL and testbench
======================================

Name: esfa_test_sequencer

Overview:
Parametrised on-chip self-test sequencer for the ESFA datapath. Steps through a test-program ROM, issues each instruction to the ESFA design, and checks asserted results. Reports the verdict over a real 8N1 UART serial line. Adds configurable ROM/DUT latency, programme length, value width and stop-on-fail/continue modes, plus a failure count.

Parameters:
ADDR_W, 8, ROM address width; programme length limit 2^ADDR_W
DATA_W, 8, ESFA index/value/metadata/selector field width
NUM_INSTR, 1, number of instructions executed (0..2^ADDR_W)
ROM_LATENCY, 1, cycles from rom_addr change to valid rom_data (>=1)
DUT_LATENCY, 1, cycles from dut_valid to valid dut_result_* (>=1)
CLK_DIV, 868, clk cycles per UART bit (>=2)
STOP_ON_FAIL, 1, 1 = halt at first failing assert; 0 = run all, count failures

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
start  in  1  one-cycle pulse; starts a run from IDLE or DONE
rom_addr  out  ADDR_W  instruction address (pc)
rom_data  in  INSTR_W  instruction word; INSTR_W = 3+4*DATA_W
dut_valid  out  1  one-cycle issue strobe
dut_will_write  out  1  instruction field
dut_new_index  out  DATA_W  instruction field
dut_new_value  out  DATA_W  instruction field
dut_metadata  out  DATA_W  instruction field
dut_is_meta  out  1  instruction field
dut_selector  out  DATA_W  instruction field
dut_result_bool  in  1  ESFA boolean result
dut_result_value  in  DATA_W  ESFA value result
uart_txd  out  1  serial output, idle high
busy  out  1  run in progress, including the report phase
done  out  1  high from end of report until next start
pass  out  1  valid while done; 1 = no failing asserts
fail_count  out  8  failing asserts, saturating at 255
first_fail_addr  out  ADDR_W  pc of first failing assert

Behaviour:
- Reset (async, rst_n=0): state IDLE; pc=0; all dut_* outputs 0; busy=0; done=0; pass=0; fail_count=0; first_fail_addr=0; uart_txd=1 immediately, including mid-frame.
- Instruction word, LSB first: will_write[0]; new_index; new_value; metadata; is_meta; selector; assert (MSB). Each multi-bit field is DATA_W wide.
- FSM states: IDLE, FETCH, ISSUE, WAIT, CHECK, REPORT, DONE.
- IDLE/DONE + start: clear pc, fail_count, first_fail_addr and pass; set busy=1; clear done.
  - If NUM_INSTR=0, go to REPORT; otherwise go to FETCH.
- FETCH: hold rom_addr=pc for ROM_LATENCY cycles, then latch rom_data into the instruction register.
- ISSUE: drive dut_* from the instruction register; dut_valid=1 for this cycle only. dut_* fields hold until the next ISSUE.
- WAIT: DUT_LATENCY cycles.
- CHECK (one cycle):
  - If assert=1 and (dut_result_bool!=is_meta or dut_result_value!=metadata), the instruction fails.
  - On a failure, fail_count increments (saturating). On the first failure only, first_fail_addr<=pc.
  - Non-assert instructions never fail.
  - If failed and STOP_ON_FAIL=1, go to REPORT.
  - Else if pc==NUM_INSTR-1, go to REPORT.
  - Else pc<=pc+1 and go to FETCH.
- Cycles per instruction: ROM_LATENCY+DUT_LATENCY+2.
- REPORT sends a byte sequence through the UART, each byte waiting for tx_ready:
  - Pass: 0x3E.
  - Fail: 0x21, then fail_count, then first_fail_addr as ceil(ADDR_W/8) bytes, MSB byte first, zero-padded.
- After the last stop bit: done=1; pass=(fail_count==0); busy=0; go to DONE.
- start while busy is ignored. start in DONE begins a fresh run.
- UART framing: 8N1, LSB first, each bit exactly CLK_DIV cycles. Back-to-back bytes have no idle gap beyond the stop bit.
- pc never wraps: NUM_INSTR=2^ADDR_W ends at pc=2^ADDR_W-1.

Decomposition:
- Package esfa_test_pkg holds:
  - state enum;
  - field offset constants derived from DATA_W;
  - report bytes: PASS_BYTE=0x3E, FAIL_BYTE=0x21.
- Sub-module esfa_uart_tx (parameter CLK_DIV; ports clk, rst_n, tx_valid, tx_data[7:0], tx_ready, txd) owns the bit timing. tx_ready is high only when idle.

Test Plan:
- NUM_INSTR=4, all asserts match, defaults -> dut_valid pulses every 4 cycles; uart_txd frame 0x3E; done=1, pass=1, fail_count=0.
- NUM_INSTR=4, STOP_ON_FAIL=1, instr 2 mismatches value -> no dut_valid for instr 3; bytes 0x21,0x01,0x02; pass=0; first_fail_addr=2.
- STOP_ON_FAIL=0, mismatches at instrs 1 and 3 of 5 -> all 5 issued; bytes 0x21,0x02,0x01; fail_count=2.
- Mismatch on an instruction with assert=0 -> ignored; pass=1.
- ROM_LATENCY=3, DUT_LATENCY=2 -> issue spacing of 7 cycles; CLK_DIV=16 -> each bit 16 cycles; NUM_INSTR=0 -> immediate 0x3E.
- rst_n low mid-UART-frame -> uart_txd=1 and all outputs at reset values at once; start ignored while busy; start in DONE reruns with cleared counters.

Source files
------------

// File: rtl/esfa_test_pkg.sv
`default_nettype none
// ============================================================================
// Module      : esfa_test_pkg
// Description : Shared types and constants for the ESFA self-test sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
package esfa_test_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_FETCH  = 3'd1,
        ST_ISSUE  = 3'd2,
        ST_WAIT   = 3'd3,
        ST_CHECK  = 3'd4,
        ST_REPORT = 3'd5,
        ST_DONE   = 3'd6
    } state_e;

    localparam logic [7:0] PASS_BYTE = 8'h3E;
    localparam logic [7:0] FAIL_BYTE = 8'h21;

    localparam int OFF_WILL_WRITE = 0;
    localparam int OFF_NEW_INDEX  = 1;

    // Instruction word layout, LSB first, every multi-bit field dw wide.
    function automatic int off_new_value(input int dw); return 1 + dw;     endfunction
    function automatic int off_metadata (input int dw); return 1 + 2 * dw; endfunction
    function automatic int off_is_meta  (input int dw); return 1 + 3 * dw; endfunction
    function automatic int off_selector (input int dw); return 2 + 3 * dw; endfunction
    function automatic int off_assert   (input int dw); return 2 + 4 * dw; endfunction

endpackage
`default_nettype wire

// File: rtl/esfa_uart_tx.sv
`default_nettype none
// ============================================================================
// Module      : esfa_uart_tx
// Description : 8N1 UART transmitter, LSB first, CLK_DIV clocks per bit.
// Revision    : 1.0 - initial release
// ============================================================================
module esfa_uart_tx #(
    parameter int CLK_DIV = 868
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       tx_valid,
    input  logic [7:0] tx_data,
    output logic       tx_ready,
    output logic       txd
);

    localparam int CNT_W = $clog2(CLK_DIV);
    localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLK_DIV - 1);
    localparam logic [CNT_W-1:0] STOP_LAST = CNT_W'(CLK_DIV - 2);

    logic             busy_q, busy_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [3:0]       bit_q, bit_d;
    logic [7:0]       data_q, data_d;
    logic             txd_q, txd_d;
    logic             w_bit_end;

    // The stop bit is cut one cycle short in the busy state; the idle cycle that
    // follows completes it, so a byte accepted there starts with no extra gap.
    always_comb begin
        busy_d    = busy_q;
        cnt_d     = cnt_q;
        bit_d     = bit_q;
        data_d    = data_q;
        txd_d     = txd_q;
        w_bit_end = (bit_q == 4'd9) ? (cnt_q == STOP_LAST) : (cnt_q == BIT_LAST);
        if (!busy_q) begin
            if (tx_valid) begin
                busy_d = 1'b1;
                cnt_d  = '0;
                bit_d  = 4'd0;
                data_d = tx_data;
                txd_d  = 1'b0;
            end
        end else if (w_bit_end) begin
            cnt_d = '0;
            if (bit_q == 4'd9) begin
                busy_d = 1'b0;
            end else begin
                bit_d = bit_q + 4'd1;
                txd_d = (bit_q == 4'd8) ? 1'b1 : data_q[bit_q[2:0]];
            end
        end else begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy_q <= 1'b0;
            cnt_q  <= '0;
            bit_q  <= 4'd0;
            data_q <= 8'd0;
            txd_q  <= 1'b1;
        end else begin
            busy_q <= busy_d;
            cnt_q  <= cnt_d;
            bit_q  <= bit_d;
            data_q <= data_d;
            txd_q  <= txd_d;
        end
    end

    assign tx_ready = !busy_q;
    assign txd      = txd_q;

endmodule
`default_nettype wire

// File: rtl/esfa_test_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : esfa_test_sequencer
// Description : Runs a ROM test programme against the ESFA datapath, checks
//               asserted results and reports the verdict over a UART.
// Revision    : 1.0 - initial release
// ============================================================================
module esfa_test_sequencer
    import esfa_test_pkg::*;
#(
    parameter int ADDR_W       = 8,
    parameter int DATA_W       = 8,
    parameter int NUM_INSTR    = 1,
    parameter int ROM_LATENCY  = 1,
    parameter int DUT_LATENCY  = 1,
    parameter int CLK_DIV      = 868,
    parameter int STOP_ON_FAIL = 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    output logic [ADDR_W-1:0]     rom_addr,
    input  logic [3+4*DATA_W-1:0] rom_data,
    output logic                  dut_valid,
    output logic                  dut_will_write,
    output logic [DATA_W-1:0]     dut_new_index,
    output logic [DATA_W-1:0]     dut_new_value,
    output logic [DATA_W-1:0]     dut_metadata,
    output logic                  dut_is_meta,
    output logic [DATA_W-1:0]     dut_selector,
    input  logic                  dut_result_bool,
    input  logic [DATA_W-1:0]     dut_result_value,
    output logic                  uart_txd,
    output logic                  busy,
    output logic                  done,
    output logic                  pass,
    output logic [7:0]            fail_count,
    output logic [ADDR_W-1:0]     first_fail_addr
);

    localparam int INSTR_W    = 3 + 4 * DATA_W;
    localparam int OFF_VAL    = off_new_value(DATA_W);
    localparam int OFF_META   = off_metadata(DATA_W);
    localparam int OFF_IM     = off_is_meta(DATA_W);
    localparam int OFF_SEL    = off_selector(DATA_W);
    localparam int OFF_ASSERT = off_assert(DATA_W);
    localparam int ADDR_BYTES = (ADDR_W + 7) / 8;
    localparam int FAIL_LEN   = 2 + ADDR_BYTES;
    localparam int RPT_W      = $clog2(FAIL_LEN + 1);
    localparam int LAT_MAX    = (ROM_LATENCY > DUT_LATENCY) ? ROM_LATENCY : DUT_LATENCY;
    localparam int LAT_W      = $clog2(LAT_MAX + 1);
    localparam logic [ADDR_W-1:0] LAST_PC = ADDR_W'((NUM_INSTR > 0) ? NUM_INSTR - 1 : 0);

    state_e              state_q, state_d;
    logic [ADDR_W-1:0]   pc_q, pc_d;
    logic [LAT_W-1:0]    lat_q, lat_d;
    logic [INSTR_W-1:0]  instr_q, instr_d;
    logic                dut_valid_q, dut_valid_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;
    logic                pass_q, pass_d;
    logic [7:0]          fail_count_q, fail_count_d;
    logic [ADDR_W-1:0]   ffa_q, ffa_d;
    logic [RPT_W-1:0]    rpt_idx_q, rpt_idx_d;

    logic                w_fail;
    logic                w_failing;
    logic [RPT_W-1:0]    w_rpt_len;
    logic [8*ADDR_BYTES-1:0] w_addr_pad;
    logic [7:0]          w_tx_data;
    logic                w_tx_valid;
    logic                w_tx_ready;

    // Report byte selection: verdict, then count and big-endian address on failure.
    always_comb begin
        w_failing  = (fail_count_q != 8'd0);
        w_rpt_len  = w_failing ? RPT_W'(FAIL_LEN) : RPT_W'(1);
        w_addr_pad = (8 * ADDR_BYTES)'(ffa_q);
        w_tx_data  = PASS_BYTE;
        if (w_failing) begin
            if (rpt_idx_q == RPT_W'(0)) begin
                w_tx_data = FAIL_BYTE;
            end else if (rpt_idx_q == RPT_W'(1)) begin
                w_tx_data = fail_count_q;
            end
            for (int j = 0; j < ADDR_BYTES; j++) begin
                if (rpt_idx_q == RPT_W'(2 + j)) begin
                    w_tx_data = w_addr_pad[8*(ADDR_BYTES-1-j) +: 8];
                end
            end
        end
        w_tx_valid = (state_q == ST_REPORT) && (rpt_idx_q != w_rpt_len);
    end

    always_comb begin
        state_d      = state_q;
        pc_d         = pc_q;
        lat_d        = lat_q;
        instr_d      = instr_q;
        dut_valid_d  = 1'b0;
        busy_d       = busy_q;
        done_d       = done_q;
        pass_d       = pass_q;
        fail_count_d = fail_count_q;
        ffa_d        = ffa_q;
        rpt_idx_d    = rpt_idx_q;
        w_fail       = instr_q[OFF_ASSERT] &&
                       ((dut_result_bool != instr_q[OFF_IM]) ||
                        (dut_result_value != instr_q[OFF_META +: DATA_W]));
        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    pc_d         = '0;
                    lat_d        = '0;
                    fail_count_d = 8'd0;
                    ffa_d        = '0;
                    pass_d       = 1'b0;
                    done_d       = 1'b0;
                    busy_d       = 1'b1;
                    rpt_idx_d    = '0;
                    state_d      = (NUM_INSTR == 0) ? ST_REPORT : ST_FETCH;
                end
            end
            ST_FETCH: begin
                if (lat_q == LAT_W'(ROM_LATENCY - 1)) begin
                    instr_d     = rom_data;
                    lat_d       = '0;
                    dut_valid_d = 1'b1;
                    state_d     = ST_ISSUE;
                end else begin
                    lat_d = lat_q + 1'b1;
                end
            end
            ST_ISSUE: begin
                state_d = ST_WAIT;
            end
            ST_WAIT: begin
                if (lat_q == LAT_W'(DUT_LATENCY - 1)) begin
                    lat_d   = '0;
                    state_d = ST_CHECK;
                end else begin
                    lat_d = lat_q + 1'b1;
                end
            end
            ST_CHECK: begin
                if (w_fail) begin
                    if (fail_count_q != 8'hFF) begin
                        fail_count_d = fail_count_q + 8'd1;
                    end
                    if (fail_count_q == 8'd0) begin
                        ffa_d = pc_q;
                    end
                end
                if ((w_fail && (STOP_ON_FAIL != 0)) || (pc_q == LAST_PC)) begin
                    state_d = ST_REPORT;
                end else begin
                    pc_d    = pc_q + 1'b1;
                    state_d = ST_FETCH;
                end
            end
            ST_REPORT: begin
                if (w_tx_valid && w_tx_ready) begin
                    rpt_idx_d = rpt_idx_q + 1'b1;
                end else if ((rpt_idx_q == w_rpt_len) && w_tx_ready) begin
                    done_d  = 1'b1;
                    pass_d  = !w_failing;
                    busy_d  = 1'b0;
                    state_d = ST_DONE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            pc_q         <= '0;
            lat_q        <= '0;
            instr_q      <= '0;
            dut_valid_q  <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            pass_q       <= 1'b0;
            fail_count_q <= 8'd0;
            ffa_q        <= '0;
            rpt_idx_q    <= '0;
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            lat_q        <= lat_d;
            instr_q      <= instr_d;
            dut_valid_q  <= dut_valid_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
            pass_q       <= pass_d;
            fail_count_q <= fail_count_d;
            ffa_q        <= ffa_d;
            rpt_idx_q    <= rpt_idx_d;
        end
    end

    esfa_uart_tx #(
        .CLK_DIV (CLK_DIV)
    ) u_uart_tx (
        .clk      (clk),
        .rst_n    (rst_n),
        .tx_valid (w_tx_valid),
        .tx_data  (w_tx_data),
        .tx_ready (w_tx_ready),
        .txd      (uart_txd)
    );

    assign rom_addr        = pc_q;
    assign dut_valid       = dut_valid_q;
    assign dut_will_write  = instr_q[OFF_WILL_WRITE];
    assign dut_new_index   = instr_q[OFF_NEW_INDEX +: DATA_W];
    assign dut_new_value   = instr_q[OFF_VAL +: DATA_W];
    assign dut_metadata    = instr_q[OFF_META +: DATA_W];
    assign dut_is_meta     = instr_q[OFF_IM];
    assign dut_selector    = instr_q[OFF_SEL +: DATA_W];
    assign busy            = busy_q;
    assign done            = done_q;
    assign pass            = pass_q;
    assign fail_count      = fail_count_q;
    assign first_fail_addr = ffa_q;

endmodule
`default_nettype wire

// File: tb/tb_esfa_test_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_esfa_test_sequencer
// Description : Directed self-checking bench for esfa_test_sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_esfa_test_sequencer;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n;
    int   cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_checks = 0;
    int n_errors = 0;
    int t_start  = 0;

    // Instance 0: 4 instrs, stop on fail, latencies 1/1
    logic        start0 = 1'b0;
    logic [7:0]  rom_addr0;
    logic [34:0] rom_data0;
    logic        dv0, ww0, im0, txd0, busy0, done0, pass0;
    logic [7:0]  idx0, val0, meta0, sel0, fc0, ffa0;
    logic        rb0 = 1'b0;
    logic [7:0]  rv0 = 8'd0;
    logic [34:0] rom0 [0:7];

    // Instance 1: 5 instrs, run-all, ROM latency 3, DUT latency 2
    logic        start1 = 1'b0;
    logic [7:0]  rom_addr1;
    logic [34:0] rom_data1;
    logic        dv1, ww1, im1, txd1, busy1, done1, pass1;
    logic [7:0]  idx1, val1, meta1, sel1, fc1, ffa1;
    logic        rb1 = 1'b0;
    logic [7:0]  rv1 = 8'd0;
    logic [34:0] rom1 [0:7];
    logic [34:0] p1 = '0, p2 = '0;
    logic        s_v = 1'b0, s_b = 1'b0;
    logic [7:0]  s_val = 8'd0;

    // Instance 2: empty programme
    logic        start2 = 1'b0;
    logic [7:0]  rom_addr2;
    logic        dv2, ww2, im2, txd2, busy2, done2, pass2;
    logic [7:0]  idx2, val2, meta2, sel2, fc2, ffa2;

    int vq0[$];
    int vq1[$];

    esfa_test_sequencer #(.ADDR_W(8), .DATA_W(8), .NUM_INSTR(4), .ROM_LATENCY(1),
        .DUT_LATENCY(1), .CLK_DIV(16), .STOP_ON_FAIL(1)) u_dut0 (
        .clk(clk), .rst_n(rst_n), .start(start0), .rom_addr(rom_addr0), .rom_data(rom_data0),
        .dut_valid(dv0), .dut_will_write(ww0), .dut_new_index(idx0), .dut_new_value(val0),
        .dut_metadata(meta0), .dut_is_meta(im0), .dut_selector(sel0),
        .dut_result_bool(rb0), .dut_result_value(rv0), .uart_txd(txd0), .busy(busy0),
        .done(done0), .pass(pass0), .fail_count(fc0), .first_fail_addr(ffa0));

    esfa_test_sequencer #(.ADDR_W(8), .DATA_W(8), .NUM_INSTR(5), .ROM_LATENCY(3),
        .DUT_LATENCY(2), .CLK_DIV(16), .STOP_ON_FAIL(0)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .start(start1), .rom_addr(rom_addr1), .rom_data(rom_data1),
        .dut_valid(dv1), .dut_will_write(ww1), .dut_new_index(idx1), .dut_new_value(val1),
        .dut_metadata(meta1), .dut_is_meta(im1), .dut_selector(sel1),
        .dut_result_bool(rb1), .dut_result_value(rv1), .uart_txd(txd1), .busy(busy1),
        .done(done1), .pass(pass1), .fail_count(fc1), .first_fail_addr(ffa1));

    esfa_test_sequencer #(.ADDR_W(8), .DATA_W(8), .NUM_INSTR(0), .ROM_LATENCY(1),
        .DUT_LATENCY(1), .CLK_DIV(16), .STOP_ON_FAIL(1)) u_dut2 (
        .clk(clk), .rst_n(rst_n), .start(start2), .rom_addr(rom_addr2), .rom_data(35'd0),
        .dut_valid(dv2), .dut_will_write(ww2), .dut_new_index(idx2), .dut_new_value(val2),
        .dut_metadata(meta2), .dut_is_meta(im2), .dut_selector(sel2),
        .dut_result_bool(1'b0), .dut_result_value(8'd0), .uart_txd(txd2), .busy(busy2),
        .done(done2), .pass(pass2), .fail_count(fc2), .first_fail_addr(ffa2));

    // ROM and ESFA stand-ins: result echoes {will_write, new_value}.
    assign rom_data0 = rom0[rom_addr0[2:0]];
    always @(posedge clk) if (dv0) begin rb0 <= ww0; rv0 <= val0; end

    always @(posedge clk) begin
        p1    <= rom1[rom_addr1[2:0]];
        p2    <= p1;
        s_v   <= dv1;
        s_b   <= ww1;
        s_val <= val1;
        if (s_v) begin rb1 <= s_b; rv1 <= s_val; end
    end
    assign rom_data1 = p2;

    always @(negedge clk) begin
        if (dv0 === 1'b1) vq0.push_back(cyc);
        if (dv1 === 1'b1) vq1.push_back(cyc);
    end

    function automatic logic [34:0] mk(input logic a, input logic ww, input logic [7:0] idx,
                                       input logic [7:0] val, input logic [7:0] meta,
                                       input logic im, input logic [7:0] sel);
        return {a, sel, im, meta, val, idx, ww};
    endfunction

    function automatic logic txd_of(input int which);
        case (which)
            0:       return txd0;
            1:       return txd1;
            default: return txd2;
        endcase
    endfunction

    function automatic logic done_of(input int which);
        case (which)
            0:       return done0;
            1:       return done1;
            default: return done2;
        endcase
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic pulse(input int which);
        @(negedge clk);
        case (which)
            0:       start0 = 1'b1;
            1:       start1 = 1'b1;
            default: start2 = 1'b1;
        endcase
        @(negedge clk);
        start0 = 1'b0;
        start1 = 1'b0;
        start2 = 1'b0;
    endtask

    task automatic rx_byte(input int which, input string tag, input logic [7:0] exp);
        int n = 0;
        logic [7:0] b = 8'd0;
        while (txd_of(which) !== 1'b0 && n < 3000) begin
            @(negedge clk);
            n++;
        end
        if (n >= 3000) begin
            check({tag, "_no_start"}, 64'd0, 64'd1);
            return;
        end
        t_start = cyc;
        repeat (8) @(negedge clk);
        check({tag, "_start_bit"}, 64'(txd_of(which)), 64'd0);
        for (int k = 0; k < 8; k++) begin
            repeat (16) @(negedge clk);
            b[k] = txd_of(which);
        end
        repeat (16) @(negedge clk);
        check({tag, "_stop_bit"}, 64'(txd_of(which)), 64'd1);
        check(tag, 64'(b), 64'(exp));
    endtask

    task automatic wait_done(input int which);
        int n = 0;
        while (done_of(which) !== 1'b1 && n < 5000) begin
            @(negedge clk);
            n++;
        end
        if (n >= 5000) check("done_timeout", 64'd0, 64'd1);
    endtask

    initial begin
        int base;
        rst_n = 1'b0;
        for (int i = 0; i < 8; i++) begin
            rom0[i] = mk(1'b1, i[0], 8'(i), 8'(16 + i), 8'(16 + i), i[0], 8'(160 + i));
            rom1[i] = '0;
        end
        repeat (3) @(negedge clk);
        check("reset_state", {busy0, done0, pass0, fc0, ffa0, txd0, dv0, rom_addr0},
              {1'b0, 1'b0, 1'b0, 8'd0, 8'd0, 1'b1, 1'b0, 8'd0});
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // All asserts match
        base = vq0.size();
        pulse(0);
        rx_byte(0, "A_byte", 8'h3E);
        wait_done(0);
        check("A_frame_len", 64'(cyc - t_start), 64'd160);
        check("A_status", {busy0, pass0, fc0}, {1'b0, 1'b1, 8'd0});
        check("A_issues", 64'(vq0.size() - base), 64'd4);
        for (int j = base + 1; j < vq0.size(); j++) check("A_gap", 64'(vq0[j] - vq0[j-1]), 64'd4);
        check("A_fields", {ww0, idx0, val0, meta0, im0, sel0},
              {1'b1, 8'h03, 8'h13, 8'h13, 1'b1, 8'hA3});

        // Stop on fail at instr 2; start while busy must be ignored
        rom0[2] = mk(1'b1, 1'b0, 8'h02, 8'h12, 8'h13, 1'b0, 8'hA2);
        base = vq0.size();
        pulse(0);
        check("B_start_clears", {busy0, done0, pass0, fc0, ffa0}, {1'b1, 1'b0, 1'b0, 8'd0, 8'd0});
        rx_byte(0, "B_byte0", 8'h21);
        pulse(0);
        rx_byte(0, "B_byte1", 8'h01);
        rx_byte(0, "B_byte2", 8'h02);
        wait_done(0);
        check("B_status", {busy0, pass0, fc0, ffa0}, {1'b0, 1'b0, 8'd1, 8'd2});
        check("B_issues", 64'(vq0.size() - base), 64'd3);

        // Mismatch on a non-assert instruction is ignored; rerun from DONE clears counters
        rom0[2] = mk(1'b1, 1'b0, 8'h02, 8'h12, 8'h12, 1'b0, 8'hA2);
        rom0[1] = mk(1'b0, 1'b1, 8'h01, 8'h11, 8'h55, 1'b0, 8'hA1);
        pulse(0);
        check("D_rerun_clears", {busy0, done0, fc0, ffa0}, {1'b1, 1'b0, 8'd0, 8'd0});
        rx_byte(0, "D_byte", 8'h3E);
        wait_done(0);
        check("D_status", {pass0, fc0}, {1'b1, 8'd0});

        // Run-all mode, failures at 1 and 3, longer latencies
        for (int i = 0; i < 5; i++)
            rom1[i] = mk(1'b1, 1'b0, 8'(i), 8'(32 + i), (i == 1 || i == 3) ? 8'h77 : 8'(32 + i),
                         1'b0, 8'(176 + i));
        base = vq1.size();
        pulse(1);
        rx_byte(1, "C_byte0", 8'h21);
        rx_byte(1, "C_byte1", 8'h02);
        rx_byte(1, "C_byte2", 8'h01);
        wait_done(1);
        check("C_status", {busy1, pass1, fc1, ffa1}, {1'b0, 1'b0, 8'd2, 8'd1});
        check("C_issues", 64'(vq1.size() - base), 64'd5);
        for (int j = base + 1; j < vq1.size(); j++) check("C_gap", 64'(vq1[j] - vq1[j-1]), 64'd7);

        // Empty programme reports pass straight away
        pulse(2);
        rx_byte(2, "E_byte", 8'h3E);
        wait_done(2);
        check("E_status", {busy2, pass2, fc2, dv2}, {1'b0, 1'b1, 8'd0, 1'b0});

        // Asynchronous reset in the middle of a UART frame
        pulse(0);
        begin
            int n = 0;
            while (txd0 !== 1'b0 && n < 3000) begin
                @(negedge clk);
                n++;
            end
            check("F_frame_started", 64'(n < 3000), 64'd1);
        end
        repeat (20) @(negedge clk);
        check("F_mid_frame_low", 64'(txd0), 64'd0);
        #2;
        rst_n = 1'b0;
        #1;
        check("F_async_reset", {txd0, busy0, done0, pass0, fc0, ffa0, dv0, rom_addr0},
              {1'b1, 1'b0, 1'b0, 1'b0, 8'd0, 8'd0, 1'b0, 8'd0});
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
`default_nettype wire
